// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's PC-register, instruction-memory, redirect and decode signals.
// The master side is the fetch controller; the slave side is its environment.
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic [31:0] new_pc;
  logic        pc_wen;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  pc,
    output new_pc,
    output pc_wen,
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_target,
    input  stall,
    output inst_valid,
    output inst,
    output inst_pc
  );

  modport slave (
    output pc,
    input  new_pc,
    input  pc_wen,
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_target,
    output stall,
    input  inst_valid,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding request, sole writer of the PC register,
// hands fetched words to decode and honours branch/jump redirects with top priority.
module fetch_ctrl (
  input  logic          clock,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_latched_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_req_addr;
  logic [31:0] w_seq_pc;
  logic        w_accept;
  logic        w_fetch_done;
  logic        w_release;
  logic        w_req_valid;
  logic        w_pc_wen;
  logic [31:0] w_new_pc;
  logic        w_unused;

  assign w_redirect    = bus.redirect_valid;
  assign w_redirect_pc = {bus.redirect_target[31:2], 2'b00};
  assign w_req_addr    = {bus.pc[31:2], 2'b00};
  assign w_seq_pc      = r_latched_addr + 32'd4;
  assign w_unused      = &{1'b0, bus.pc[1:0], bus.redirect_target[1:0]};

  assign w_accept     = (r_state == S_REQ)  && bus.imem_req_ready && !w_redirect;
  assign w_fetch_done = (r_state == S_WAIT) && bus.imem_rsp_valid && !w_redirect;
  assign w_release    = (r_state == S_HOLD) && (w_redirect || !bus.stall);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ: begin
        if (w_accept) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect racing the response drops it now; otherwise it must be drained in DROP.
        if (w_redirect) begin
          w_next_state = bus.imem_rsp_valid ? S_REQ : S_DROP;
        end else if (bus.imem_rsp_valid) begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_release) begin
          w_next_state = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  always_comb begin
    w_req_valid = 1'b0;
    w_pc_wen    = 1'b0;
    w_new_pc    = 32'h0;
    if (!reset) begin
      if (w_redirect) begin
        w_pc_wen = 1'b1;
        w_new_pc = w_redirect_pc;
      end else begin
        case (r_state)
          S_REQ:   w_req_valid = 1'b1;
          S_WAIT: begin
            if (bus.imem_rsp_valid) begin
              w_pc_wen = 1'b1;
              w_new_pc = w_seq_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_latched_addr <= 32'h0;
      r_inst_valid   <= 1'b0;
      r_inst         <= NOP_INST;
      r_inst_pc      <= 32'h0;
    end else begin
      if (w_accept) begin
        r_latched_addr <= w_req_addr;
      end
      // Decode sees NOP whenever nothing valid is presented.
      if (w_fetch_done) begin
        r_inst_valid <= 1'b1;
        r_inst       <= bus.imem_rsp_data;
        r_inst_pc    <= r_latched_addr;
      end else if (w_release) begin
        r_inst_valid <= 1'b0;
        r_inst       <= NOP_INST;
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = w_req_addr;
  assign bus.pc_wen         = w_pc_wen;
  assign bus.new_pc         = w_new_pc;
  assign bus.inst_valid     = r_inst_valid;
  assign bus.inst           = r_inst;
  assign bus.inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a behavioural PC register plus hand-driven memory,
// redirect and stall stimulus with hand-computed expectations.
module tb_fetch_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PC register owned by the environment; reset value 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.pc <= 32'h0;
    end else if (bus.pc_wen) begin
      bus.pc <= bus.new_pc;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Starts settled in REQ with ready=1; ends settled in HOLD.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [31:0] npc);
    chk1("req_valid", bus.imem_req_valid, 1'b1);
    chk("req_addr", bus.imem_req_addr, a);
    cyc();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    settle();
    chk1("wait_pc_wen", bus.pc_wen, 1'b1);
    chk("wait_new_pc", bus.new_pc, npc);
    chk1("wait_req_valid", bus.imem_req_valid, 1'b0);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    settle();
    chk1("hold_inst_valid", bus.inst_valid, 1'b1);
    chk("hold_inst", bus.inst, d);
    chk("hold_inst_pc", bus.inst_pc, a);
    $display("fetch addr=%h data=%h new_pc=%h", a, d, npc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = 32'h0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.stall           = 1'b0;

    // Reset state
    repeat (2) cyc();
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rst_pc_wen", bus.pc_wen, 1'b0);
    chk("rst_new_pc", bus.new_pc, 32'h0);
    chk1("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);

    // Sequential fetch, one instruction per three cycles
    reset = 1'b0;
    bus.imem_req_ready = 1'b1;
    settle();
    fetch(32'h0, 32'h1111_1111, 32'h4);
    cyc();
    fetch(32'h4, 32'h2222_2222, 32'h8);
    cyc();
    fetch(32'h8, 32'h3333_3333, 32'hC);

    // Stall hold, with a stray response that must be ignored
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.imem_rsp_valid = (i == 1);
      bus.imem_rsp_data  = 32'h0BAD_0BAD;
      cyc();
      bus.imem_rsp_valid = 1'b0;
      settle();
      chk1("stall_inst_valid", bus.inst_valid, 1'b1);
      chk("stall_inst", bus.inst, 32'h3333_3333);
      chk("stall_inst_pc", bus.inst_pc, 32'h8);
      chk1("stall_req_valid", bus.imem_req_valid, 1'b0);
      chk1("stall_pc_wen", bus.pc_wen, 1'b0);
    end
    bus.stall = 1'b0;
    cyc();
    chk1("resume_req_valid", bus.imem_req_valid, 1'b1);
    chk("resume_req_addr", bus.imem_req_addr, 32'hC);
    chk1("resume_inst_valid", bus.inst_valid, 1'b0);
    chk("resume_inst_nop", bus.inst, 32'h0);

    // Redirect in WAIT, response two cycles later is dropped
    cyc();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h103;
    settle();
    chk1("rdw_pc_wen", bus.pc_wen, 1'b1);
    chk("rdw_new_pc", bus.new_pc, 32'h100);
    chk1("rdw_req_valid", bus.imem_req_valid, 1'b0);
    cyc();
    bus.redirect_valid = 1'b0;
    settle();
    chk1("drop_req_valid", bus.imem_req_valid, 1'b0);
    cyc();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    settle();
    chk1("drop_pc_wen", bus.pc_wen, 1'b0);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    settle();
    chk1("drop_inst_valid", bus.inst_valid, 1'b0);
    chk("drop_inst", bus.inst, 32'h0);
    chk1("drop_req_valid_after", bus.imem_req_valid, 1'b1);
    chk("drop_req_addr", bus.imem_req_addr, 32'h100);
    $display("redirect in WAIT to 0x103 -> next addr %h", bus.imem_req_addr);

    // Redirect coincident with response
    cyc();
    bus.imem_rsp_valid  = 1'b1;
    bus.imem_rsp_data   = 32'h5555_5555;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    settle();
    chk1("coin_pc_wen", bus.pc_wen, 1'b1);
    chk("coin_new_pc", bus.new_pc, 32'h40);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    settle();
    chk1("coin_inst_valid", bus.inst_valid, 1'b0);
    chk1("coin_req_valid", bus.imem_req_valid, 1'b1);
    chk("coin_req_addr", bus.imem_req_addr, 32'h40);

    // Response while in REQ is ignored
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    settle();
    chk1("reqrsp_pc_wen", bus.pc_wen, 1'b0);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    settle();
    chk1("reqrsp_req_valid", bus.imem_req_valid, 1'b1);
    chk1("reqrsp_inst_valid", bus.inst_valid, 1'b0);

    // Redirect in REQ to the top word, then wrap and HOLD redirect
    bus.imem_req_ready  = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFE;
    settle();
    chk1("rdq_req_valid", bus.imem_req_valid, 1'b0);
    chk("rdq_new_pc", bus.new_pc, 32'hFFFF_FFFC);
    cyc();
    bus.redirect_valid = 1'b0;
    settle();
    fetch(32'hFFFF_FFFC, 32'h7777_7777, 32'h0);
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h200;
    settle();
    chk1("rdh_pc_wen", bus.pc_wen, 1'b1);
    chk("rdh_new_pc", bus.new_pc, 32'h200);
    cyc();
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    settle();
    chk1("rdh_inst_valid", bus.inst_valid, 1'b0);
    chk1("rdh_req_valid", bus.imem_req_valid, 1'b1);
    chk("rdh_req_addr", bus.imem_req_addr, 32'h200);

    // Reset mid-WAIT, stale response after release is ignored
    cyc();
    reset = 1'b1;
    settle();
    chk1("rstw_req_valid", bus.imem_req_valid, 1'b0);
    chk1("rstw_pc_wen", bus.pc_wen, 1'b0);
    chk("rstw_new_pc", bus.new_pc, 32'h0);
    chk("rstw_inst_pc", bus.inst_pc, 32'h0);
    cyc();
    reset = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h9999_9999;
    settle();
    chk1("stale_pc_wen", bus.pc_wen, 1'b0);
    chk1("stale_req_valid", bus.imem_req_valid, 1'b1);
    chk("stale_req_addr", bus.imem_req_addr, 32'h0);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    settle();
    chk1("stale_inst_valid", bus.inst_valid, 1'b0);
    chk1("stale_wait_pc_wen", bus.pc_wen, 1'b0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hABAB_ABAB;
    settle();
    chk("post_new_pc", bus.new_pc, 32'h4);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    settle();
    chk1("post_inst_valid", bus.inst_valid, 1'b1);
    chk("post_inst", bus.inst, 32'hABAB_ABAB);
    chk("post_inst_pc", bus.inst_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that drives the CPU's program-counter register: it reads the current PC, fetches the instruction at that address through a valid/ready instruction-memory port, and hands it to decode. It is also the sole writer of the PC register, producing the next-PC value and its write enable for sequential advance (+4) and for branch/jump redirects. At most one memory request is outstanding at any time.

## Interface
- NOP_INST, 32'h00000000, value driven on `inst` whenever `inst_valid` is 0
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- pc  in  32  current PC, from the PC register output
- new_pc  out  32  next PC, to the PC register `newPC`
- pc_wen  out  1  write enable, to the PC register `WEN`
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  response data valid, one-cycle pulse per accepted request
- imem_rsp_data  in  32  fetched instruction
- redirect_valid  in  1  resolved branch/jump, one-cycle pulse
- redirect_target  in  32  redirect destination
- stall  in  1  decode cannot accept an instruction this cycle
- inst_valid  out  1  instruction presented to decode
- inst  out  32  instruction word
- inst_pc  out  32  address of `inst`

## Operation
- FSM states: REQ, WAIT, HOLD, DROP. Reset state is REQ.
- Address formation:
  - `imem_req_addr` = {pc[31:2],2'b00}.
  - The sequential next PC is latched_addr + 4, modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000.
  - On redirect, `new_pc` = {redirect_target[31:2],2'b00}.
- Redirect has priority over every other event in every state. On a redirect cycle, `pc_wen`=1, `new_pc`=target, and `imem_req_valid` is forced to 0.
- REQ:
  - `imem_req_valid`=1.
  - If `imem_req_ready`=1 and no redirect: latch `imem_req_addr` as latched_addr, go to WAIT.
  - On redirect: stay in REQ.
- WAIT:
  - If `imem_rsp_valid`=1 and no redirect: latch `imem_rsp_data` into `inst` and latched_addr into `inst_pc`, assert `pc_wen` with `new_pc`=latched_addr+4, go to HOLD.
  - On redirect with no response this cycle: go to DROP.
  - On redirect with a response in the same cycle: discard the response, go to REQ.
- HOLD:
  - `inst_valid`=1; `inst` and `inst_pc` are stable.
  - If `stall`=0: the instruction is consumed, go to REQ.
  - If `stall`=1: stay in HOLD. No request is issued and `pc_wen`=0.
  - On redirect: squash the held instruction (`inst_valid`=0 next cycle), go to REQ.
- DROP:
  - Wait for the outstanding response. When `imem_rsp_valid`=1, discard it and go to REQ.
  - A further redirect in DROP rewrites the PC again; the state stays DROP unless the response arrives in the same cycle.
- `imem_rsp_valid` outside WAIT/DROP is ignored: no state change, no latch.

## Timing
- `inst_valid`, `inst`, and `inst_pc` are registered.
- `imem_req_valid`, `imem_req_addr`, `pc_wen`, and `new_pc` are combinational from state and inputs.
- While reset=1:
  - `imem_req_valid`=0, `pc_wen`=0, `new_pc`=0.
  - `inst_valid`=0, `inst`=NOP_INST, `inst_pc`=0.
  - latched_addr=0; state=REQ.
- First cycle after reset release: `imem_req_valid`=1 with addr = the PC register's reset value.
- `pc_wen` is a single-cycle pulse; the PC register updates at the following edge. The next REQ therefore already sees the new `pc`.
- With a ready memory and one-cycle response latency, the minimum rate is one instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset asserted in any state aborts immediately. Any response that arrives after release while in REQ is ignored.

## Test plan
- Sequential fetch:
  - Stimulus: reset, PC reset 0, `imem_req_ready`=1, response one cycle after acceptance, `stall`=0.
  - Response: request addrs 0x0, 0x4, 0x8; `pc_wen` pulses with `new_pc` 0x4, 0x8, 0xC; `inst_pc` 0x0, 0x4, 0x8, one every 3 cycles.
- Stall hold:
  - Stimulus: `stall`=1 for 5 cycles in HOLD.
  - Response: `inst`/`inst_pc`/`inst_valid` unchanged, `imem_req_valid`=0, `pc_wen`=0. Fetch resumes the cycle after `stall` drops.
- Redirect in WAIT:
  - Stimulus: redirect to 0x103 in WAIT, then response 0xDEADBEEF 2 cycles later.
  - Response: `new_pc`=0x100 with `pc_wen`=1; 0xDEADBEEF is never shown on `inst`; next request addr is 0x100.
- Redirect coincident with response:
  - Stimulus: redirect to 0x40 in the same cycle as `imem_rsp_valid`.
  - Response: response discarded, `new_pc`=0x40, next state REQ, `inst_valid` stays 0.
- Wrap and HOLD redirect:
  - Stimulus: fetch at 0xFFFFFFFC, then redirect to 0x200 while in HOLD.
  - Response: `new_pc`=0x0, `inst_pc`=0xFFFFFFFC; the redirect squashes `inst_valid` the next cycle and the next request addr is 0x200.
- Reset mid-WAIT:
  - Stimulus: assert reset in WAIT; deliver a response the cycle after release.
  - Response: outputs at reset values; the stale response is ignored; the request to the PC reset address proceeds.
